// File: rtl/eth_regbank_pkg.sv
// ============================================================================
// Module      : eth_regbank_pkg
// Description : Shared access-mode encodings for the Ethernet MAC register bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_regbank_pkg;

    typedef enum logic [1:0] {
        ETH_RB_RW  = 2'd0,
        ETH_RB_RO  = 2'd1,
        ETH_RB_W1C = 2'd2,
        ETH_RB_RC  = 2'd3
    } eth_rb_mode_e;

endpackage

`default_nettype wire

// File: rtl/eth_regbank_cell.sv
// ============================================================================
// Module      : eth_regbank_cell
// Description : One control/status register with byte-lane writes and a
//               per-instance access mode (RW, RO, W1C, RC).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_regbank_cell
    import eth_regbank_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [1:0]       MODE        = ETH_RB_RW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sync_reset,
    input  logic                 i_wr_en,
    input  logic                 i_rd_clr,
    input  logic [WIDTH-1:0]     i_data,
    input  logic [WIDTH/8-1:0]   i_byte_en,
    input  logic [WIDTH-1:0]     i_hw,
    output logic [WIDTH-1:0]     o_value
);

    localparam int NUM_BYTES = WIDTH / 8;

    logic [WIDTH-1:0] w_wr_mask;
    logic [WIDTH-1:0] w_value_d;
    logic [WIDTH-1:0] r_value_q;

    always_comb begin
        w_wr_mask = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            w_wr_mask[b*8 +: 8] = {8{i_byte_en[b] & i_wr_en}};
        end
    end

    // Hardware set is OR-ed in last so it wins over a same-cycle clear.
    always_comb begin
        w_value_d = r_value_q;
        if (i_sync_reset) begin
            w_value_d = RESET_VALUE;
        end else begin
            case (MODE)
                ETH_RB_RW:  w_value_d = (r_value_q & ~w_wr_mask) | (i_data & w_wr_mask);
                ETH_RB_RO:  w_value_d = i_hw;
                ETH_RB_W1C: w_value_d = (r_value_q & ~(i_data & w_wr_mask)) | i_hw;
                default:    w_value_d = (i_rd_clr ? '0 : r_value_q) | i_hw;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value_q <= RESET_VALUE;
        end else begin
            r_value_q <= w_value_d;
        end
    end

    assign o_value = r_value_q;

endmodule

`default_nettype wire

// File: rtl/eth_regbank.sv
// ============================================================================
// Module      : eth_regbank
// Description : Parametrised CSR bank: address decode, registered reads with
//               valid/error strobes, and NUM_REGS mode-configurable cells.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_regbank
    import eth_regbank_pkg::*;
#(
    parameter int                        WIDTH       = 32,
    parameter int                        NUM_REGS    = 8,
    parameter int                        ADDR_W      = 3,
    parameter logic [NUM_REGS*WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [2*NUM_REGS-1:0]     MODE        = '0
) (
    input  logic                        Clk,
    input  logic                        Resetn,
    input  logic                        SyncReset,
    input  logic [ADDR_W-1:0]           Addr,
    input  logic [WIDTH-1:0]            DataIn,
    input  logic [WIDTH/8-1:0]          ByteEn,
    input  logic                        Write,
    input  logic                        Read,
    input  logic [NUM_REGS*WIDTH-1:0]   HwIn,
    output logic [WIDTH-1:0]            DataOut,
    output logic                        ReadValid,
    output logic                        AddrErr,
    output logic [NUM_REGS*WIDTH-1:0]   RegOut
);

    logic                w_in_range;
    logic [NUM_REGS-1:0] w_wr_sel;
    logic [NUM_REGS-1:0] w_rd_sel;
    logic [WIDTH-1:0]    w_rd_data;
    logic [WIDTH-1:0]    w_cell_value [NUM_REGS];

    logic [WIDTH-1:0]    w_data_out_d;
    logic                w_read_valid_d;
    logic                w_addr_err_d;
    logic [WIDTH-1:0]    r_data_out_q;
    logic                r_read_valid_q;
    logic                r_addr_err_q;

    // Out-of-range addresses match no cell, so the read mux yields zero.
    always_comb begin
        w_in_range = (int'(Addr) < NUM_REGS);
        w_wr_sel   = '0;
        w_rd_sel   = '0;
        w_rd_data  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(Addr) == i) begin
                w_wr_sel[i] = Write;
                w_rd_sel[i] = Read;
                w_rd_data   = w_cell_value[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
        eth_regbank_cell #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE[gi*WIDTH +: WIDTH]),
            .MODE        (MODE[2*gi +: 2])
        ) u_cell (
            .clk          (Clk),
            .rst_n        (Resetn),
            .i_sync_reset (SyncReset),
            .i_wr_en      (w_wr_sel[gi]),
            .i_rd_clr     (w_rd_sel[gi]),
            .i_data       (DataIn),
            .i_byte_en    (ByteEn),
            .i_hw         (HwIn[gi*WIDTH +: WIDTH]),
            .o_value      (w_cell_value[gi])
        );

        assign RegOut[gi*WIDTH +: WIDTH] = w_cell_value[gi];
    end

    always_comb begin
        w_data_out_d   = r_data_out_q;
        w_read_valid_d = 1'b0;
        w_addr_err_d   = 1'b0;
        if (SyncReset) begin
            w_data_out_d = '0;
        end else begin
            w_read_valid_d = Read;
            w_addr_err_d   = (Read | Write) & ~w_in_range;
            if (Read) begin
                w_data_out_d = w_rd_data;
            end
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_data_out_q   <= '0;
            r_read_valid_q <= 1'b0;
            r_addr_err_q   <= 1'b0;
        end else begin
            r_data_out_q   <= w_data_out_d;
            r_read_valid_q <= w_read_valid_d;
            r_addr_err_q   <= w_addr_err_d;
        end
    end

    assign DataOut   = r_data_out_q;
    assign ReadValid = r_read_valid_q;
    assign AddrErr   = r_addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_regbank.sv
// ============================================================================
// Module      : tb_eth_regbank
// Description : Self-checking bench for eth_regbank: directed scenarios plus
//               randomized traffic against a behavioural register model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_eth_regbank;

    localparam int WIDTH = 32;
    localparam int NREGS = 6;
    localparam int AW    = 3;
    localparam int NB    = WIDTH / 8;

    localparam int M_RW  = 0;
    localparam int M_RO  = 1;
    localparam int M_W1C = 2;
    localparam int M_RC  = 3;

    // reg0 RW, reg1 RW, reg2 W1C, reg3 RC, reg4 RO, reg5 W1C
    localparam logic [2*NREGS-1:0]     MODES = 12'b10_01_11_10_00_00;
    localparam logic [NREGS*WIDTH-1:0] RV    = {32'hFFFF_0000, 32'h0, 32'h0,
                                                32'h0, 32'h0, 32'h0000_00FF};

    int          reg_mode [NREGS] = '{M_RW, M_RW, M_W1C, M_RC, M_RO, M_W1C};
    logic [31:0] rst_val  [NREGS] = '{32'h0000_00FF, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_0000};

    logic                     Clk = 1'b0;
    logic                     Resetn = 1'b0;
    logic                     SyncReset = 1'b0;
    logic [AW-1:0]            Addr = '0;
    logic [WIDTH-1:0]         DataIn = '0;
    logic [NB-1:0]            ByteEn = '0;
    logic                     Write = 1'b0;
    logic                     Read = 1'b0;
    logic [NREGS*WIDTH-1:0]   HwIn = '0;
    logic [WIDTH-1:0]         DataOut;
    logic                     ReadValid;
    logic                     AddrErr;
    logic [NREGS*WIDTH-1:0]   RegOut;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_reg [NREGS];
    logic [31:0] m_dout;
    logic        m_valid;
    logic        m_err;

    eth_regbank #(
        .WIDTH       (WIDTH),
        .NUM_REGS    (NREGS),
        .ADDR_W      (AW),
        .RESET_VALUE (RV),
        .MODE        (MODES)
    ) dut (
        .Clk       (Clk),
        .Resetn    (Resetn),
        .SyncReset (SyncReset),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .ByteEn    (ByteEn),
        .Write     (Write),
        .Read      (Read),
        .HwIn      (HwIn),
        .DataOut   (DataOut),
        .ReadValid (ReadValid),
        .AddrErr   (AddrErr),
        .RegOut    (RegOut)
    );

    initial forever #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_reg(input int i);
        return RegOut[i*WIDTH +: WIDTH];
    endfunction

    task automatic set_hw(input int i, input logic [31:0] v);
        HwIn[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_reg[i] = rst_val[i];
        m_dout  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    // Applies one clock worth of the register-bank rules to the model.
    task automatic model_step();
        logic [31:0] old [NREGS];
        logic [31:0] hw;
        int          a;
        bit          inr;
        a   = int'(Addr);
        inr = (a < NREGS);
        if (SyncReset) begin
            model_reset();
            return;
        end
        old     = m_reg;
        m_valid = Read;
        if (Read) m_dout = inr ? old[a] : 32'h0;
        m_err = (Read || Write) && !inr;
        for (int i = 0; i < NREGS; i++) begin
            hw = HwIn[i*WIDTH +: WIDTH];
            case (reg_mode[i])
                M_RW: begin
                    if (Write && a == i)
                        for (int b = 0; b < NB; b++)
                            if (ByteEn[b]) m_reg[i][b*8 +: 8] = DataIn[b*8 +: 8];
                end
                M_RO: m_reg[i] = hw;
                M_W1C: begin
                    if (Write && a == i)
                        for (int b = 0; b < NB; b++)
                            if (ByteEn[b]) m_reg[i][b*8 +: 8] = old[i][b*8 +: 8] & ~DataIn[b*8 +: 8];
                    m_reg[i] = m_reg[i] | hw;
                end
                default: begin
                    if (Read && a == i) m_reg[i] = 32'h0;
                    m_reg[i] = m_reg[i] | hw;
                end
            endcase
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NREGS; i++) check($sformatf("reg%0d", i), dut_reg(i), m_reg[i]);
        check("DataOut", DataOut, m_dout);
        check("ReadValid", {31'b0, ReadValid}, {31'b0, m_valid});
        check("AddrErr", {31'b0, AddrErr}, {31'b0, m_err});
    endtask

    task automatic idle();
        Write = 1'b0; Read = 1'b0; SyncReset = 1'b0;
        HwIn = '0; ByteEn = '0; DataIn = '0; Addr = '0;
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [NB-1:0] be);
        idle();
        Addr = AW'(a); DataIn = d; ByteEn = be; Write = 1'b1;
        cycle();
    endtask

    task automatic do_read(input int a);
        idle();
        Addr = AW'(a); Read = 1'b1;
        cycle();
    endtask

    initial begin
        logic [31:0] snap [NREGS];
        model_reset();
        @(posedge Clk); #1;
        check("rst_reg0", dut_reg(0), 32'h0000_00FF);
        check("rst_reg5", dut_reg(5), 32'hFFFF_0000);
        check("rst_DataOut", DataOut, 32'h0);
        check_all();
        #2 Resetn = 1'b1;

        // RW byte-lane write and read-back
        do_write(1, 32'hAABB_CCDD, 4'b0101);
        check("rw_bytes", dut_reg(1), 32'h00BB_00DD);
        do_read(1);
        check("rw_read", DataOut, 32'h00BB_00DD);
        check("rw_valid", {31'b0, ReadValid}, 32'h1);

        // Simultaneous read and write returns the pre-write value
        idle();
        Addr = 3'd1; DataIn = 32'h1111_1111; ByteEn = 4'hF; Write = 1'b1; Read = 1'b1;
        cycle();
        check("rdwr_data", DataOut, 32'h00BB_00DD);
        check("rdwr_reg", dut_reg(1), 32'h1111_1111);

        // W1C: hardware set beats software clear
        idle(); set_hw(2, 32'h0F); cycle();
        check("w1c_set", dut_reg(2), 32'h0F);
        idle();
        Addr = 3'd2; DataIn = 32'h03; ByteEn = 4'hF; Write = 1'b1; set_hw(2, 32'h01);
        cycle();
        check("w1c_collide", dut_reg(2), 32'h0D);

        // RC: read clears, except bits set by hardware during the read
        idle(); set_hw(3, 32'h80); cycle();
        idle(); Addr = 3'd3; Read = 1'b1; set_hw(3, 32'h01);
        cycle();
        check("rc_data", DataOut, 32'h80);
        check("rc_after", dut_reg(3), 32'h01);

        // Out-of-range accesses
        do_read(7);
        check("oor_data", DataOut, 32'h0);
        check("oor_valid", {31'b0, ReadValid}, 32'h1);
        check("oor_err", {31'b0, AddrErr}, 32'h1);
        snap = m_reg;
        do_write(6, 32'hFFFF_FFFF, 4'hF);
        check("oor_werr", {31'b0, AddrErr}, 32'h1);
        for (int i = 0; i < NREGS; i++) check($sformatf("oor_keep%0d", i), dut_reg(i), snap[i]);

        // SyncReset discards same-cycle strobes
        idle();
        SyncReset = 1'b1; Addr = 3'd1; DataIn = 32'h1234; ByteEn = 4'hF; Write = 1'b1; Read = 1'b1;
        cycle();
        check("srst_reg1", dut_reg(1), 32'h0);
        check("srst_reg0", dut_reg(0), 32'h0000_00FF);
        check("srst_valid", {31'b0, ReadValid}, 32'h0);
        check("srst_data", DataOut, 32'h0);

        // Randomized traffic
        repeat (400) begin
            idle();
            Addr      = AW'($urandom_range(0, 7));
            Write     = ($urandom_range(0, 2) == 0);
            Read      = ($urandom_range(0, 2) == 0);
            DataIn    = $urandom;
            ByteEn    = NB'($urandom);
            SyncReset = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NREGS; i++)
                if ($urandom_range(0, 3) == 0) set_hw(i, $urandom & $urandom & $urandom);
            cycle();
        end

        // Asynchronous reset mid-cycle
        do_write(0, 32'h1234_5678, 4'hF);
        do_read(0);
        check("pre_arst_data", DataOut, 32'h1234_5678);
        idle();
        #2 Resetn = 1'b0;
        #1;
        check("arst_reg0", dut_reg(0), 32'h0000_00FF);
        check("arst_data", DataOut, 32'h0);
        check("arst_valid", {31'b0, ReadValid}, 32'h0);
        check("arst_err", {31'b0, AddrErr}, 32'h0);
        model_reset();
        @(posedge Clk); #1;
        check_all();
        #3 Resetn = 1'b1;

        repeat (100) begin
            idle();
            Addr   = AW'($urandom_range(0, 7));
            Write  = ($urandom_range(0, 1) == 0);
            Read   = ($urandom_range(0, 1) == 0);
            DataIn = $urandom;
            ByteEn = NB'($urandom);
            for (int i = 0; i < NREGS; i++)
                if ($urandom_range(0, 3) == 0) set_hw(i, $urandom & $urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
